mc_alu_control: RTL and testbench
=================================

Name: mc_alu_control

Overview:
- Multi-cycle control sequencer that drives the processor's ALU opcode/funct interface.
- Fetches a 32-bit instruction, decodes it, and steps through execute, memory and write-back.
- Issues register-file, data-memory and PC strobes, and uses the ALU zero flag to resolve branches.
- Sits between instruction memory and the datapath (ALU, register file, PC, data memory).

Parameters:
- DMEM_TIMEOUT, 15, max cycles in MEM waiting for dmem_ack before a bus error (1..255)
- FETCH_TIMEOUT, 15, max cycles in FETCH waiting for imem_valid before a bus error (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- imem_rdata  in  32  instruction word; opcode [31:26], funct [5:0]
- imem_valid  in  1  instruction word valid
- imem_req  out  1  fetch request
- dmem_ack  in  1  data memory access complete
- dmem_req  out  1  data memory access request
- dmem_we  out  1  1 = store, 0 = load
- alu_zflag  in  1  ALU zero flag (1 when result == 0)
- alu_opcode  out  6  ALU operation class
- alu_funct  out  6  ALU R-type function
- alu_src_imm  out  1  ALU operand 2: 1 = immediate, 0 = rt
- rf_we  out  1  register-file write strobe
- rf_dst_sel  out  1  destination: 1 = rd, 0 = rt
- wb_sel  out  1  write-back source: 1 = memory, 0 = ALU
- pc_inc  out  1  PC += 4 strobe
- pc_branch  out  1  PC = branch target strobe
- pc_jump  out  1  PC = jump target strobe
- ir_load  out  1  capture instruction into IR
- illegal  out  1  sticky illegal-instruction flag
- bus_err  out  1  sticky memory-timeout flag
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (clk edge with rst_n=0): state=FETCH, internal IR=0, counter=0, illegal=0, bus_err=0.
- Reset mid-operation abandons the instruction; dmem_req and all strobes are low the cycle after.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Other encodings go to FETCH.
- Outputs are combinational from state and IR. All outputs are 0 in FETCH except imem_req/ir_load.
- Instruction set (opcode -> ALU opcode, funct):
  - 000010 R-type -> 000010, ir[5:0]; legal funct 0..4 (add, sub, and, or, slt)
  - 000001 ADDI -> 000001, imm
  - 000000 LW -> 000000, imm
  - 000101 SW -> 000000, imm
  - 000011 BEQ -> 000011, rt
  - 000110 J -> no ALU
- FETCH:
  - imem_req=1.
  - When imem_valid=1: ir_load=1 that cycle, IR<=imem_rdata, go to DECODE.
  - Counter counts wait cycles. At FETCH_TIMEOUT without valid: bus_err<=1, go to TRAP.
- DECODE:
  - Any unlisted opcode, or R-type with funct>4: illegal<=1, go to TRAP.
  - Otherwise go to EXEC.
  - alu_opcode, alu_funct and alu_src_imm are driven from DECODE through WB and held stable.
  - alu_funct=0 for non-R-type.
- EXEC:
  - R-type, ADDI -> WB.
  - LW, SW -> MEM; counter cleared.
  - BEQ: pc_branch=alu_zflag, pc_inc=!alu_zflag, then -> FETCH.
  - J: pc_jump=1, then -> FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for SW.
  - On dmem_ack: SW -> pc_inc=1, then FETCH; LW -> WB.
  - At DMEM_TIMEOUT without ack: bus_err<=1, go to TRAP.
  - dmem_ack in the timeout cycle wins.
- WB:
  - rf_we=1 and pc_inc=1 for one cycle, then FETCH.
  - rf_dst_sel=1 for R-type only; wb_sel=1 for LW only.
- TRAP: all strobes 0; stays in TRAP until reset.
- Exactly one PC strobe per completed instruction.
- Latency from fetch-accept cycle to next FETCH:
  - R-type, ADDI: 4 cycles
  - BEQ, J: 3 cycles
  - LW: 5+wait cycles
  - SW: 4+wait cycles

Optional Feature:
- Macro MC_ALU_CONTROL_BNE_EN.
- Defined: opcode 000111 = BNE. Decoded like BEQ (ALU opcode 000011, rt), but in EXEC pc_branch=!alu_zflag and pc_inc=alu_zflag.
- Undefined: 000111 is illegal (illegal<=1, TRAP).

Test Plan:
- Reset, then R-type add (opcode 000010, funct 000000) with imem_valid in cycle 1 -> alu_opcode=000010, alu_funct=0 in DECODE..WB; rf_we=1, rf_dst_sel=1, pc_inc=1 in cycle 4 only; state_dbg back to 0.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; WB gives rf_we=1, wb_sel=1, rf_dst_sel=0; alu_opcode=000000, alu_src_imm=1.
- BEQ with alu_zflag=1, then BEQ with alu_zflag=0 -> pc_branch=1, pc_inc=0 for the first; pc_branch=0, pc_inc=1 for the second; rf_we never asserted.
- R-type funct 000101, and opcode 111111 -> illegal=1, state_dbg=5, no strobes; rst_n=0 for one edge -> illegal=0, state FETCH.
- SW with no dmem_ack (DMEM_TIMEOUT=15) -> bus_err=1 after 15 MEM cycles, TRAP. Repeat with ack in cycle 15 -> pc_inc=1, bus_err stays 0.
- Opcode 000111 with alu_zflag=0 -> macro defined: pc_branch=1. Macro undefined: illegal=1.

Source files
------------

// File: rtl/mc_alu_control.sv
// Multi-cycle control sequencer driving the ALU opcode/funct interface.
// Optional BNE support is enabled by defining MC_ALU_CONTROL_BNE_EN.
module mc_alu_control #(
    parameter int unsigned DMEM_TIMEOUT  = 15,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        alu_zflag,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_funct,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic        rf_dst_sel,
    output logic        wb_sel,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        pc_jump,
    output logic        ir_load,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_R    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000110;
`ifdef MC_ALU_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000111;
`endif

    localparam logic [5:0] ALU_MEM = 6'b000000;
    localparam logic [5:0] ALU_ADD = 6'b000001;
    localparam logic [5:0] ALU_R   = 6'b000010;
    localparam logic [5:0] ALU_BR  = 6'b000011;

    localparam logic [7:0] F_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [7:0] M_LAST = 8'(DMEM_TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] ir_q;
    logic [7:0]  cnt_q;
    logic        illegal_q;
    logic        bus_err_q;

    logic [5:0]  op;
    logic        is_r, is_lw, is_sw, is_beq, is_bne, is_j;
    logic        dec_legal;
    logic [5:0]  dec_op;
    logic [5:0]  dec_fn;
    logic        dec_imm;
    logic        unused_ir;

    assign op     = ir_q[31:26];
    assign is_r   = (op == OP_R);
    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_beq = (op == OP_BEQ);
    assign is_j   = (op == OP_J);
`ifdef MC_ALU_CONTROL_BNE_EN
    assign is_bne = (op == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_ir = ^ir_q[25:6];

    // Decode IR into ALU controls; illegal encodings decode to all zeros.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 6'd0;
        dec_fn    = 6'd0;
        dec_imm   = 1'b0;
        case (op)
            OP_R: begin
                if (ir_q[5:0] <= 6'd4) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_R;
                    dec_fn    = ir_q[5:0];
                end
            end
            OP_ADDI: begin
                dec_legal = 1'b1;
                dec_op    = ALU_ADD;
                dec_imm   = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec_legal = 1'b1;
                dec_op    = ALU_MEM;
                dec_imm   = 1'b1;
            end
            OP_BEQ: begin
                dec_legal = 1'b1;
                dec_op    = ALU_BR;
            end
`ifdef MC_ALU_CONTROL_BNE_EN
            OP_BNE: begin
                dec_legal = 1'b1;
                dec_op    = ALU_BR;
            end
`endif
            OP_J: dec_legal = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencer: state, IR, wait counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            cnt_q     <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        cnt_q   <= 8'd0;
                        state_q <= S_DECODE;
                    end else if (cnt_q == F_LAST) begin
                        bus_err_q <= 1'b1;
                        cnt_q     <= 8'd0;
                        state_q   <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    cnt_q <= 8'd0;
                    if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else if (is_beq || is_bne || is_j) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        cnt_q   <= 8'd0;
                        state_q <= is_sw ? S_FETCH : S_WB;
                    end else if (cnt_q == M_LAST) begin
                        bus_err_q <= 1'b1;
                        cnt_q     <= 8'd0;
                        state_q   <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WB:   state_q <= S_FETCH;
                S_TRAP: state_q <= S_TRAP;
                default: begin
                    cnt_q   <= 8'd0;
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Output strobes from current state, IR and the handshake inputs.
    always_comb begin
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_opcode  = 6'd0;
        alu_funct   = 6'd0;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        rf_dst_sel  = 1'b0;
        wb_sel      = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        pc_jump     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_valid;
            end
            S_DECODE: begin
                alu_opcode  = dec_op;
                alu_funct   = dec_fn;
                alu_src_imm = dec_imm;
            end
            S_EXEC: begin
                alu_opcode  = dec_op;
                alu_funct   = dec_fn;
                alu_src_imm = dec_imm;
                if (is_beq) begin
                    pc_branch = alu_zflag;
                    pc_inc    = !alu_zflag;
                end else if (is_bne) begin
                    pc_branch = !alu_zflag;
                    pc_inc    = alu_zflag;
                end else if (is_j) begin
                    pc_jump = 1'b1;
                end
            end
            S_MEM: begin
                alu_opcode  = dec_op;
                alu_funct   = dec_fn;
                alu_src_imm = dec_imm;
                dmem_req    = 1'b1;
                dmem_we     = is_sw;
                pc_inc      = dmem_ack && is_sw;
            end
            S_WB: begin
                alu_opcode  = dec_op;
                alu_funct   = dec_fn;
                alu_src_imm = dec_imm;
                rf_we       = 1'b1;
                pc_inc      = 1'b1;
                rf_dst_sel  = is_r;
                wb_sel      = is_lw;
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_alu_control.sv
// Scoreboard bench for mc_alu_control: directed instructions, expected
// commit/trap records queued by stimulus and checked by a monitor.
module tb_mc_alu_control;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] op;
        logic [5:0] fn;
        logic       src;
        logic       rfwe;
        logic       dst;
        logic       wbs;
        logic       inc;
        logic       br;
        logic       jmp;
        logic       ill;
        logic       berr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic        imem_req;
    logic        dmem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        alu_zflag = 1'b0;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_funct;
    logic        alu_src_imm;
    logic        rf_we;
    logic        rf_dst_sel;
    logic        wb_sel;
    logic        pc_inc;
    logic        pc_branch;
    logic        pc_jump;
    logic        ir_load;
    logic        illegal;
    logic        bus_err;
    logic [2:0]  state_dbg;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    logic [2:0] prev_st = 3'd0;

    mc_alu_control #(.DMEM_TIMEOUT(15), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .imem_req(imem_req),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_zflag(alu_zflag), .alu_opcode(alu_opcode),
        .alu_funct(alu_funct), .alu_src_imm(alu_src_imm),
        .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel),
        .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump),
        .ir_load(ir_load), .illegal(illegal), .bus_err(bus_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endfunction

    function automatic obs_t mk(logic [2:0] st, logic [5:0] op,
                                logic [5:0] fn, logic [8:0] f);
        obs_t o;
        o = {st, op, fn, f};
        return o;
    endfunction

    // Monitor: compare on every PC/RF commit cycle and on TRAP entry.
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        o = {state_dbg, alu_opcode, alu_funct, alu_src_imm, rf_we,
             rf_dst_sel, wb_sel, pc_inc, pc_branch, pc_jump,
             illegal, bus_err};
        if (rst_n && ((rf_we | pc_inc | pc_branch | pc_jump) ||
                      (state_dbg == 3'd5 && prev_st != 3'd5))) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected", 32'(o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mon_record", 32'(o), 32'(e));
            end
        end
        prev_st = state_dbg;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        imem_valid = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
        chk("rst_fetch_out", {29'd0, imem_req, dmem_req,
            rf_we | pc_inc | pc_branch | pc_jump}, 32'h4);
    endtask

    task automatic run(input string nm, input logic [31:0] instr,
                       input logic z, input int ack_at, input obs_t e,
                       input int x_lat, input int x_dreq, input int x_we,
                       input int x_rfwe, input int x_pcs);
        int n, lat, mreq, we, rfwe, pcs, bad;
        mreq = 0; we = 0; rfwe = 0; pcs = 0; bad = 0; lat = -1;
        chk({nm, "_pre"}, 32'(state_dbg), 32'd0);
        exp_q.push_back(e);
        alu_zflag = z;
        imem_rdata = instr;
        imem_valid = 1'b1;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        n = 1;
        while (n <= 200) begin
            if (state_dbg == 3'd0 || state_dbg == 3'd5) begin
                lat = n;
                break;
            end
            if (alu_opcode !== e.op) bad++;
            if (dmem_req) begin
                mreq++;
                if (dmem_we) we++;
            end
            dmem_ack = dmem_req && (mreq == ack_at);
            #1;
            rfwe += int'(rf_we);
            pcs += int'(pc_inc | pc_branch | pc_jump);
            @(posedge clk); #1;
            n++;
        end
        dmem_ack = 1'b0;
        chk({nm, "_lat"}, lat, x_lat);
        chk({nm, "_dreq"}, mreq, x_dreq);
        chk({nm, "_we"}, we, x_we);
        chk({nm, "_rfwe"}, rfwe, x_rfwe);
        chk({nm, "_pcs"}, pcs, x_pcs);
        chk({nm, "_opstable"}, bad, 0);
    endtask

    task automatic trap_hold(input string nm, input logic ill, input logic be);
        int act;
        act = 0;
        repeat (3) begin
            @(posedge clk); #1;
            act += int'(rf_we | pc_inc | pc_branch | pc_jump |
                        dmem_req | imem_req);
        end
        chk({nm, "_hold_state"}, 32'(state_dbg), 32'd5);
        chk({nm, "_hold_quiet"}, act, 0);
        chk({nm, "_hold_flags"}, {30'd0, illegal, bus_err}, {30'd0, ill, be});
    endtask

    initial begin
        int k;
        reset_dut();
        // f = {src, rfwe, dst, wbs, inc, br, jmp, ill, berr}
        run("add", {6'b000010, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0}, 1'b0, 0,
            mk(3'd4, 6'd2, 6'd0, 9'b0_1_1_0_1_0_0_0_0), 4, 0, 0, 1, 1);
        run("lw", {6'b000000, 5'd4, 5'd5, 16'h0024}, 1'b0, 4,
            mk(3'd4, 6'd0, 6'd0, 9'b1_1_0_1_1_0_0_0_0), 8, 4, 0, 1, 1);
        run("addi", {6'b000001, 5'd4, 5'd5, 16'h0005}, 1'b0, 0,
            mk(3'd4, 6'd1, 6'd0, 9'b1_1_0_0_1_0_0_0_0), 4, 0, 0, 1, 1);
        run("sw1", {6'b000101, 5'd4, 5'd5, 16'h0013}, 1'b0, 1,
            mk(3'd3, 6'd0, 6'd0, 9'b1_0_0_0_1_0_0_0_0), 4, 1, 1, 0, 1);
        run("beq_t", {6'b000011, 5'd1, 5'd2, 16'h0002}, 1'b1, 0,
            mk(3'd2, 6'd3, 6'd0, 9'b0_0_0_0_0_1_0_0_0), 3, 0, 0, 0, 1);
        run("beq_n", {6'b000011, 5'd1, 5'd2, 16'h0002}, 1'b0, 0,
            mk(3'd2, 6'd3, 6'd0, 9'b0_0_0_0_1_0_0_0_0), 3, 0, 0, 0, 1);
        run("j", {6'b000110, 26'h0000_123}, 1'b0, 0,
            mk(3'd2, 6'd0, 6'd0, 9'b0_0_0_0_0_0_1_0_0), 3, 0, 0, 0, 1);
        run("slt", {6'b000010, 5'd7, 5'd8, 5'd9, 5'd0, 6'd4}, 1'b1, 0,
            mk(3'd4, 6'd2, 6'd4, 9'b0_1_1_0_1_0_0_0_0), 4, 0, 0, 1, 1);
        run("sw15", {6'b000101, 5'd4, 5'd5, 16'h0000}, 1'b0, 15,
            mk(3'd3, 6'd0, 6'd0, 9'b1_0_0_0_1_0_0_0_0), 18, 15, 15, 0, 1);
`ifdef MC_ALU_CONTROL_BNE_EN
        run("bne", {6'b000111, 5'd1, 5'd2, 16'h0004}, 1'b0, 0,
            mk(3'd2, 6'd3, 6'd0, 9'b0_0_0_0_0_1_0_0_0), 3, 0, 0, 0, 1);
`else
        run("bne_ill", {6'b000111, 5'd1, 5'd2, 16'h0004}, 1'b0, 0,
            mk(3'd5, 6'd0, 6'd0, 9'b0_0_0_0_0_0_0_1_0), 2, 0, 0, 0, 0);
        trap_hold("bne_ill", 1'b1, 1'b0);
        reset_dut();
`endif
        run("fn5", {6'b000010, 5'd1, 5'd2, 5'd3, 5'd0, 6'd5}, 1'b0, 0,
            mk(3'd5, 6'd0, 6'd0, 9'b0_0_0_0_0_0_0_1_0), 2, 0, 0, 0, 0);
        trap_hold("fn5", 1'b1, 1'b0);
        reset_dut();
        run("op3f", {6'b111111, 26'h3FF_FFFF}, 1'b0, 0,
            mk(3'd5, 6'd0, 6'd0, 9'b0_0_0_0_0_0_0_1_0), 2, 0, 0, 0, 0);
        trap_hold("op3f", 1'b1, 1'b0);
        reset_dut();
        run("sw_to", {6'b000101, 5'd4, 5'd5, 16'h0008}, 1'b0, 0,
            mk(3'd5, 6'd0, 6'd0, 9'b0_0_0_0_0_0_0_0_1), 18, 15, 15, 0, 0);
        trap_hold("sw_to", 1'b0, 1'b1);
        reset_dut();

        // Fetch timeout: 15 idle FETCH cycles, then TRAP with bus_err.
        exp_q.push_back(mk(3'd5, 6'd0, 6'd0, 9'b0_0_0_0_0_0_0_0_1));
        k = 0;
        while (state_dbg == 3'd0 && k < 100) begin
            k++;
            @(posedge clk); #1;
        end
        chk("fetch_to_cycles", k, 15);
        trap_hold("fetch_to", 1'b0, 1'b1);
        reset_dut();

        // Reset while waiting in MEM abandons the load.
        imem_rdata = {6'b000000, 5'd4, 5'd5, 16'h0010};
        imem_valid = 1'b1;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("midop_in_mem", {28'd0, state_dbg, dmem_req}, 32'h7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midop_rst", {27'd0, state_dbg, dmem_req,
            rf_we | pc_inc | pc_branch | pc_jump}, 32'd0);
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
